// File: rtl/cache_memory.sv
// Direct-mapped, write-back, write-allocate cache with a word-wide CPU port,
// a line-wide memory-driver port and a full-cache flush walker.
module cache_memory #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 4,
  localparam int BO = $clog2(WORD_W/8),
  localparam int WO = $clog2(LINE_WORDS),
  localparam int IX = $clog2(LINES),
  localparam int LA = ADDR_W - BO - WO
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         REQ,
  input  logic                         RW,
  input  logic [ADDR_W-1:0]            ADDRESS,
  input  logic [WORD_W-1:0]            WDATA,
  output logic [WORD_W-1:0]            RDATA,
  output logic                         DONE,
  output logic                         PENDING,
  input  logic                         FLUSH,
  output logic                         FLUSH_DONE,
  output logic                         DRIVER_REQ,
  output logic                         DRIVER_RW,
  output logic [LA-1:0]                DRIVER_ADDRESS,
  output logic [WORD_W*LINE_WORDS-1:0] DRIVER_WDATA,
  input  logic [WORD_W*LINE_WORDS-1:0] DRIVER_RDATA,
  input  logic                         DRIVER_ACK
);
  localparam int TW = LA - IX;
  localparam int LW = WORD_W * LINE_WORDS;
  localparam logic [IX-1:0] LAST = IX'(LINES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FSCAN, S_FWB} state_t;
  state_t r_state, w_next;

  logic [LINES-1:0]  r_valid, r_dirty;
  logic [TW-1:0]     r_tag  [LINES];
  logic [LW-1:0]     r_data [LINES];
  logic              r_rw;
  logic [LA-1:0]     r_line;
  logic [WO-1:0]     r_word;
  logic [WORD_W-1:0] r_wdata, r_rdata;
  logic [IX-1:0]     r_fidx;
  logic              r_done, r_fdone, r_dreq, r_drw;
  logic [LA-1:0]     r_daddr;
  logic [LW-1:0]     r_dwdata;

  logic [WO-1:0] w_word;
  logic [IX-1:0] w_idx, w_lidx;
  logic [TW-1:0] w_tag;
  logic [LA-1:0] w_line;
  logic          w_hit, w_accept, w_vdirty, w_fdirty, w_flast, w_fill_ack;
  logic          w_pending, w_wb_go, w_fill_go, w_fwb_go, w_fdone_set, w_fadv;
  logic [LW-1:0] w_fill_line;
  logic          w_unused;

  assign w_word     = ADDRESS[BO +: WO];
  assign w_idx      = ADDRESS[BO+WO +: IX];
  assign w_tag      = ADDRESS[ADDR_W-1 -: TW];
  assign w_line     = ADDRESS[ADDR_W-1 -: LA];
  assign w_lidx     = r_line[IX-1:0];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_vdirty   = r_valid[w_idx] && r_dirty[w_idx];
  assign w_fdirty   = r_valid[r_fidx] && r_dirty[r_fidx];
  assign w_flast    = (r_fidx == LAST);
  assign w_accept   = (r_state == S_IDLE) && REQ;
  assign w_fill_ack = (r_state == S_FILL) && DRIVER_ACK;
  assign w_unused   = ^ADDRESS;

  always_comb begin
    w_fill_line = DRIVER_RDATA;
    if (r_rw) w_fill_line[r_word*WORD_W +: WORD_W] = r_wdata;
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (REQ) begin
                 if (!w_hit) w_next = w_vdirty ? S_WB : S_FILL;
               end else if (FLUSH) w_next = S_FSCAN;
      S_WB:    if (DRIVER_ACK) w_next = S_FILL;
      S_FILL:  if (DRIVER_ACK) w_next = S_IDLE;
      S_FSCAN: if (w_fdirty) w_next = S_FWB;
               else if (w_flast) w_next = S_IDLE;
      S_FWB:   if (DRIVER_ACK) w_next = w_flast ? S_IDLE : S_FSCAN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pending   = (r_state != S_IDLE);
    w_wb_go     = w_accept && !w_hit && w_vdirty;
    w_fill_go   = (w_accept && !w_hit && !w_vdirty) || ((r_state == S_WB) && DRIVER_ACK);
    w_fwb_go    = (r_state == S_FSCAN) && w_fdirty;
    w_fadv      = ((r_state == S_FSCAN) && !w_fdirty) || ((r_state == S_FWB) && DRIVER_ACK);
    w_fdone_set = w_fadv && w_flast;
  end

  // Driver-side fields only move when a transfer is launched, so they stay
  // stable for the whole REQ..ACK window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid  <= '0;
      r_dirty  <= '0;
      r_rw     <= 1'b0;
      r_line   <= '0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_fidx   <= '0;
      r_rdata  <= '0;
      r_done   <= 1'b0;
      r_fdone  <= 1'b0;
      r_dreq   <= 1'b0;
      r_drw    <= 1'b0;
      r_daddr  <= '0;
      r_dwdata <= '0;
    end else begin
      r_dreq  <= w_wb_go || w_fill_go || w_fwb_go;
      r_done  <= (w_accept && w_hit) || w_fill_ack;
      r_fdone <= w_fdone_set;
      if (w_accept) begin
        r_rw    <= RW;
        r_line  <= w_line;
        r_word  <= w_word;
        r_wdata <= WDATA;
      end
      if (w_accept && w_hit) begin
        if (RW) r_dirty[w_idx] <= 1'b1;
        else    r_rdata <= r_data[w_idx][w_word*WORD_W +: WORD_W];
      end
      if (w_wb_go) begin
        r_drw    <= 1'b1;
        r_daddr  <= {r_tag[w_idx], w_idx};
        r_dwdata <= r_data[w_idx];
      end
      if (w_fwb_go) begin
        r_drw    <= 1'b1;
        r_daddr  <= {r_tag[r_fidx], r_fidx};
        r_dwdata <= r_data[r_fidx];
      end
      if (w_fill_go) begin
        r_drw   <= 1'b0;
        r_daddr <= (r_state == S_IDLE) ? w_line : r_line;
      end
      if ((r_state == S_WB) && DRIVER_ACK) r_dirty[w_lidx] <= 1'b0;
      if ((r_state == S_FWB) && DRIVER_ACK) r_dirty[r_fidx] <= 1'b0;
      if (w_fill_ack) begin
        r_valid[w_lidx] <= 1'b1;
        r_dirty[w_lidx] <= r_rw;
        if (!r_rw) r_rdata <= DRIVER_RDATA[r_word*WORD_W +: WORD_W];
      end
      if ((r_state == S_IDLE) && !REQ && FLUSH) r_fidx <= '0;
      else if (w_fadv && !w_flast)              r_fidx <= r_fidx + 1'b1;
    end
  end

  // Line contents and tags are qualified by the valid bits, so no reset.
  always_ff @(posedge CLK) begin
    if (w_accept && w_hit && RW) r_data[w_idx][w_word*WORD_W +: WORD_W] <= WDATA;
    if (w_fill_ack) begin
      r_data[w_lidx] <= w_fill_line;
      r_tag[w_lidx]  <= r_line[LA-1 -: TW];
    end
  end

  assign RDATA          = r_rdata;
  assign DONE           = r_done;
  assign PENDING        = w_pending;
  assign FLUSH_DONE     = r_fdone;
  assign DRIVER_REQ     = r_dreq;
  assign DRIVER_RW      = r_drw;
  assign DRIVER_ADDRESS = r_daddr;
  assign DRIVER_WDATA   = r_dwdata;
endmodule

// File: doc/cache_memory.md
# cache_memory

Parametrised direct-mapped, write-back, write-allocate cache between the CPU-side word port and the line-wide memory driver. It generalises the single-line cache to `LINES` lines of `LINE_WORDS` words each. It adds a request/done handshake on the CPU side, a request/ack handshake on the driver side, and a full-cache flush. Hits complete in one cycle. Back-to-back hits are accepted every cycle.

## Interface
Parameters:
- `ADDR_W`, 32, CPU byte-address width
- `WORD_W`, 32, word width; a multiple of 8
- `LINE_WORDS`, 4, words per line; a power of 2, ≥2
- `LINES`, 4, number of cache lines; a power of 2, ≥2
- Derived widths:
  - BO = log2(WORD_W/8)
  - WO = log2(LINE_WORDS)
  - IX = log2(LINES)
  - LA = ADDR_W−BO−WO (line-address width)

Ports:
- `CLK`  in  1  single clock, rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `REQ`  in  1  CPU request, level; sampled only when PENDING=0
- `RW`  in  1  0=read, 1=write
- `ADDRESS`  in  ADDR_W  byte address; bits [BO-1:0] ignored
- `WDATA`  in  WORD_W  write data
- `RDATA`  out  WORD_W  read data, valid in the DONE cycle
- `DONE`  out  1  one-cycle pulse: request complete
- `PENDING`  out  1  busy; REQ and FLUSH are ignored while high
- `FLUSH`  in  1  level request to write back all dirty lines
- `FLUSH_DONE`  out  1  one-cycle pulse: flush complete
- `DRIVER_REQ`  out  1  one-cycle pulse starting a driver transfer
- `DRIVER_RW`  out  1  0=line read, 1=line write
- `DRIVER_ADDRESS`  out  LA  line address
- `DRIVER_WDATA`  out  WORD_W*LINE_WORDS  line write data
- `DRIVER_RDATA`  in  WORD_W*LINE_WORDS  line read data, valid in the ACK cycle
- `DRIVER_ACK`  in  1  one-cycle pulse: transfer complete

## Operation
- Address split: word = ADDRESS[BO+WO-1:BO], index = next IX bits, tag = remaining upper bits.
- Line address: line = {tag,index}.
- Word k of a line occupies bits [k*WORD_W +: WORD_W].
- Per-line storage: valid bit, dirty bit, tag, data. Reset clears every valid and dirty bit. Data is not reset.
- States: IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB. PENDING = (state != IDLE).
- IDLE, REQ=1: latch RW, ADDRESS and WDATA.
  - Hit (valid and tag match): a read loads RDATA; a write updates the word and sets dirty. DONE pulses next cycle. State stays IDLE.
  - Miss, victim dirty: go to WB.
  - Miss, victim clean or invalid: go to FILL.
- IDLE, REQ=0, FLUSH=1: index counter ← 0, go to FLUSH_SCAN. REQ has priority over FLUSH in the same cycle.
- WB: pulse DRIVER_REQ with DRIVER_RW=1, DRIVER_ADDRESS={victim tag,index} and DRIVER_WDATA=victim line. On DRIVER_ACK: clear dirty, go to FILL.
- FILL: pulse DRIVER_REQ with DRIVER_RW=0 and DRIVER_ADDRESS=requested line. On DRIVER_ACK:
  - Store DRIVER_RDATA and set valid and the new tag.
  - For a write, merge WDATA into the selected word before storing and set dirty=1. Otherwise set dirty=0.
  - For a read, set RDATA = selected word of DRIVER_RDATA.
  - Pulse DONE and go to IDLE.
- FLUSH_SCAN: examine one index per cycle.
  - Valid and dirty: go to FLUSH_WB.
  - Otherwise: advance. After the last index, pulse FLUSH_DONE and go to IDLE.
- FLUSH_WB: same transfer as WB for the current index. On ACK: clear dirty, advance, return to FLUSH_SCAN, or finish after the last index.
- Flush leaves valid bits unchanged.
- DRIVER_RW, DRIVER_ADDRESS and DRIVER_WDATA are held stable from the DRIVER_REQ cycle until the ACK cycle.
- DRIVER_ACK outside WB, FILL and FLUSH_WB is ignored.
- FLUSH still high in the FLUSH_DONE cycle starts another flush. This is harmless.

## Timing
- Reset values: RDATA=0, DONE=0, FLUSH_DONE=0, DRIVER_REQ=0, DRIVER_RW=0, DRIVER_ADDRESS=0, DRIVER_WDATA=0, state=IDLE, PENDING=0.
- Reset mid-transfer aborts immediately with no DONE. The driver must be reset with the block.
- Hit: REQ sampled at edge 0 → DONE and RDATA valid in cycle 1. PENDING never rises.
- Miss: DRIVER_REQ is high in the first cycle of WB and FILL. With ACK sampled at edge k, DONE is high in cycle k+1.
- Dirty-miss latency = write-back latency + fill latency + 2 cycles.
- Flush with no dirty lines: FLUSH_DONE is high LINES+1 cycles after acceptance.
- All outputs are registered except PENDING, which is decoded from state.

## Test plan
- Reset, then read 0x10 (LINES=4, LINE_WORDS=4) → DRIVER_REQ with RW=0 and DRIVER_ADDRESS=0x1. ACK with line {0x33,0x22,0x11,0x00}, word0 = 0x00 → DONE next cycle with RDATA=0x00.
- Write 0xDEADBEEF to 0x14 → DONE after 1 cycle, no DRIVER_REQ. A following read of 0x14 → RDATA=0xDEADBEEF after 1 cycle.
- Read 0x50 (index 1, new tag) → write-back first: DRIVER_RW=1, DRIVER_ADDRESS=0x1, word1=0xDEADBEEF. Then fill with DRIVER_ADDRESS=0x5, then DONE.
- Four consecutive hit REQs on 0x10, 0x14, 0x18, 0x1C → four DONE pulses in consecutive cycles, PENDING=0 throughout.
- Dirty lines at index 0 and 2, assert FLUSH → exactly two write-backs in index order 0 then 2, then FLUSH_DONE. A second flush → no DRIVER_REQ, FLUSH_DONE 5 cycles after acceptance.
- Assert RST_N=0 during FILL → DRIVER_REQ=0, PENDING=0, DONE=0 immediately. A re-read of the same address after release → miss and DRIVER_REQ.
